// File: rtl/cache_pkg.sv
// +------------------------------------------------------------------------+
// | cache_pkg                                                              |
// | Address geometry shared by the cache tag controller and the cache FSM. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

package cache_pkg;

  localparam int C_TAG_W    = 8;
  localparam int C_INDEX_W  = 4;
  localparam int C_OFFSET_W = 4;
  localparam int C_ADDR_W   = C_TAG_W + C_INDEX_W + C_OFFSET_W;

  // Field extractors for a default-geometry address {tag, index, offset}.
  function automatic logic [C_TAG_W-1:0] addr_tag(input logic [C_ADDR_W-1:0] addr);
    return addr[C_ADDR_W-1 -: C_TAG_W];
  endfunction

  function automatic logic [C_INDEX_W-1:0] addr_index(input logic [C_ADDR_W-1:0] addr);
    return addr[C_OFFSET_W +: C_INDEX_W];
  endfunction

  function automatic logic [C_OFFSET_W-1:0] addr_offset(input logic [C_ADDR_W-1:0] addr);
    return addr[C_OFFSET_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_line_status.sv
// +------------------------------------------------------------------------+
// | cache_line_status                                                      |
// | Per-line tag/valid/dirty store with FSM-driven updates on one index.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module cache_line_status
  import cache_pkg::*;
#(
  parameter int TAG_W   = C_TAG_W,
  parameter int INDEX_W = C_INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               busy,
  input  logic [INDEX_W-1:0] idx,
  input  logic [TAG_W-1:0]   tag_wr,
  input  logic               valid,
  input  logic               dirty,
  input  logic               wr_rd_sdram,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  output logic               rd_dirty
);

  localparam int LINES = 1 << INDEX_W;

  logic [TAG_W-1:0] r_tag_mem [LINES];
  logic [LINES-1:0] r_valid_mem;
  logic [LINES-1:0] r_dirty_mem;

  for (genvar i = 0; i < LINES; i++) begin : g_line
    logic w_sel;
    assign w_sel = busy && (idx == INDEX_W'(i));

    // A completed write-back wins over any fill/dirty strobe in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_tag_mem[i]   <= '0;
        r_valid_mem[i] <= 1'b0;
        r_dirty_mem[i] <= 1'b0;
      end else if (w_sel) begin
        if (wr_rd_sdram) begin
          r_valid_mem[i] <= 1'b0;
          r_dirty_mem[i] <= 1'b0;
        end else begin
          if (valid) begin
            r_tag_mem[i]   <= tag_wr;
            r_valid_mem[i] <= 1'b1;
          end
          if (dirty) begin
            r_dirty_mem[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign rd_tag   = r_tag_mem[idx];
  assign rd_valid = r_valid_mem[idx];
  assign rd_dirty = r_dirty_mem[idx];

endmodule

`default_nettype wire

// File: rtl/cache_tag_ctrl.sv
// +------------------------------------------------------------------------+
// | cache_tag_ctrl                                                         |
// | CPU request capture, hit/write-back detection and SRAM/SDRAM addresses.|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module cache_tag_ctrl
  import cache_pkg::*;
#(
  parameter int TAG_W    = C_TAG_W,
  parameter int INDEX_W  = C_INDEX_W,
  parameter int OFFSET_W = C_OFFSET_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cs_cpu,
  input  logic                              wr_rd_cpu,
  input  logic [TAG_W+INDEX_W+OFFSET_W-1:0] addr_cpu,
  input  logic                              rdy,
  input  logic                              dirty,
  input  logic                              valid,
  input  logic                              wr_rd_sdram,
  input  logic [OFFSET_W-1:0]               addr_offset_counter,
  output logic                              busy,
  output logic                              wr_rd_cpu_q,
  output logic                              hit,
  output logic                              line_dirty,
  output logic                              wb_pending,
  output logic [INDEX_W+OFFSET_W-1:0]       addr_sram,
  output logic [TAG_W+INDEX_W+OFFSET_W-1:0] addr_sdram
);

  localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;

  logic                r_busy;
  logic                r_wr_rd_cpu_q;
  logic [TAG_W-1:0]    r_tag_q;
  logic [INDEX_W-1:0]  r_idx_q;
  logic [OFFSET_W-1:0] r_off_q;

  logic [TAG_W-1:0]    w_rd_tag;
  logic                w_rd_valid;
  logic                w_rd_dirty;
  logic                w_match;
  logic                w_wb_pending;
  logic [OFFSET_W-1:0] w_burst_off;

  // Only one request is tracked; a strobe coinciding with rdy is left for the CPU to retry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy        <= 1'b0;
      r_wr_rd_cpu_q <= 1'b0;
      r_tag_q       <= '0;
      r_idx_q       <= '0;
      r_off_q       <= '0;
    end else if (r_busy) begin
      if (rdy) begin
        r_busy <= 1'b0;
      end
    end else if (cs_cpu) begin
      r_busy        <= 1'b1;
      r_wr_rd_cpu_q <= wr_rd_cpu;
      r_tag_q       <= addr_cpu[ADDR_W-1 -: TAG_W];
      r_idx_q       <= addr_cpu[OFFSET_W +: INDEX_W];
      r_off_q       <= addr_cpu[OFFSET_W-1:0];
    end
  end

  cache_line_status #(
    .TAG_W   (TAG_W),
    .INDEX_W (INDEX_W)
  ) u_line_status (
    .clk         (clk),
    .rst         (rst),
    .busy        (r_busy),
    .idx         (r_idx_q),
    .tag_wr      (r_tag_q),
    .valid       (valid),
    .dirty       (dirty),
    .wr_rd_sdram (wr_rd_sdram),
    .rd_tag      (w_rd_tag),
    .rd_valid    (w_rd_valid),
    .rd_dirty    (w_rd_dirty)
  );

  assign w_match      = w_rd_valid && (w_rd_tag == r_tag_q);
  assign w_wb_pending = r_busy && w_rd_valid && w_rd_dirty && !w_match;
  // Idle memory address reads as zero so a reset mid-burst leaves nothing on the bus.
  assign w_burst_off  = r_busy ? addr_offset_counter : '0;

  assign busy        = r_busy;
  assign wr_rd_cpu_q = r_wr_rd_cpu_q;
  assign hit         = r_busy && w_match;
  assign line_dirty  = r_busy && w_rd_dirty;
  assign wb_pending  = w_wb_pending;
  assign addr_sram   = {r_idx_q, (r_busy && !w_match) ? addr_offset_counter : r_off_q};
  assign addr_sdram  = {(w_wb_pending ? w_rd_tag : r_tag_q), r_idx_q, w_burst_off};

endmodule

`default_nettype wire

// File: tb/tb_cache_tag_ctrl.sv
// +------------------------------------------------------------------------+
// | tb_cache_tag_ctrl                                                      |
// | Directed self-checking bench for cache_tag_ctrl.                       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_cache_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_cpu = 1'b0;
  logic        wr_rd_cpu = 1'b0;
  logic [15:0] addr_cpu = '0;
  logic        rdy = 1'b0;
  logic        dirty = 1'b0;
  logic        valid = 1'b0;
  logic        wr_rd_sdram = 1'b0;
  logic [3:0]  addr_offset_counter = '0;
  logic        busy;
  logic        wr_rd_cpu_q;
  logic        hit;
  logic        line_dirty;
  logic        wb_pending;
  logic [7:0]  addr_sram;
  logic [15:0] addr_sdram;

  int n_checks = 0;
  int n_pass   = 0;

  cache_tag_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .cs_cpu              (cs_cpu),
    .wr_rd_cpu           (wr_rd_cpu),
    .addr_cpu            (addr_cpu),
    .rdy                 (rdy),
    .dirty               (dirty),
    .valid               (valid),
    .wr_rd_sdram         (wr_rd_sdram),
    .addr_offset_counter (addr_offset_counter),
    .busy                (busy),
    .wr_rd_cpu_q         (wr_rd_cpu_q),
    .hit                 (hit),
    .line_dirty          (line_dirty),
    .wb_pending          (wb_pending),
    .addr_sram           (addr_sram),
    .addr_sdram          (addr_sdram)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic wr, input logic [15:0] a);
    cs_cpu = 1'b1; wr_rd_cpu = wr; addr_cpu = a;
    step();
    cs_cpu = 1'b0;
  endtask

  task automatic pulse(input logic v, input logic d, input logic s, input logic r);
    valid = v; dirty = d; wr_rd_sdram = s; rdy = r;
    step();
    valid = 1'b0; dirty = 1'b0; wr_rd_sdram = 1'b0; rdy = 1'b0;
  endtask

  initial begin
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_wr", wr_rd_cpu_q, 0);
    check("rst_hit", hit, 0);
    check("rst_ldirty", line_dirty, 0);
    check("rst_wb", wb_pending, 0);
    check("rst_sram", addr_sram, 0);
    check("rst_sdram", addr_sdram, 0);
    rst = 1'b0;
    step();

    // Cold read miss on line 3
    request(1'b0, 16'h1234);
    addr_offset_counter = 4'h2; #1;
    check("miss_busy", busy, 1);
    check("miss_hit", hit, 0);
    check("miss_wb", wb_pending, 0);
    check("miss_sram", addr_sram, 8'h32);
    check("miss_sdram", addr_sdram, 16'h1232);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("fill_hit", hit, 1);
    check("fill_sram", addr_sram, 8'h34);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("rdy_busy", busy, 0);
    check("idle_hit", hit, 0);

    // Write hit marks line dirty
    request(1'b1, 16'h1237);
    check("wh_hit", hit, 1);
    check("wh_dir", wr_rd_cpu_q, 1);
    check("wh_sram", addr_sram, 8'h37);
    pulse(1'b0, 1'b1, 1'b0, 1'b1);
    check("wh_busy", busy, 0);
    check("wh_ldirty_idle", line_dirty, 0);
    request(1'b0, 16'h1230);
    check("rh_hit", hit, 1);
    check("rh_ldirty", line_dirty, 1);
    check("rh_wb", wb_pending, 0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);

    // Conflict miss on dirty line 3
    request(1'b0, 16'h5630);
    addr_offset_counter = 4'hA; #1;
    check("cm_hit", hit, 0);
    check("cm_wb", wb_pending, 1);
    check("cm_sdram", addr_sdram, 16'h123A);
    check("cm_sram", addr_sram, 8'h3A);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("wbdone_wb", wb_pending, 0);
    check("wbdone_ldirty", line_dirty, 0);
    check("wbdone_sdram", addr_sdram, 16'h563A);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("cmfill_hit", hit, 1);
    check("cmfill_sram", addr_sram, 8'h30);

    // cs while busy is ignored; cs with rdy is not captured
    request(1'b1, 16'h7710);
    check("ign_busy_hit", hit, 1);
    check("ign_busy_sram", addr_sram, 8'h30);
    check("ign_busy_dir", wr_rd_cpu_q, 0);
    cs_cpu = 1'b1; addr_cpu = 16'h7710; rdy = 1'b1;
    step();
    cs_cpu = 1'b0; rdy = 1'b0;
    check("csrdy_busy", busy, 0);
    step();
    check("csrdy_busy2", busy, 0);

    // write-back strobe overrides fill in the same cycle
    request(1'b0, 16'h7720);
    check("inv_hit", hit, 0);
    check("inv_wb", wb_pending, 0);
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    check("prio_hit", hit, 0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);

    // Strobes while idle leave line 2 untouched
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    check("idle_str_busy", busy, 0);
    request(1'b0, 16'h7720);
    check("idle_str_hit", hit, 0);
    check("idle_str_ldirty", line_dirty, 0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);

    // Top index, valid+dirty together; no aliasing onto line 0
    request(1'b1, 16'hAAF5);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    check("top_hit", hit, 1);
    check("top_ldirty", line_dirty, 1);
    check("top_sram", addr_sram, 8'hF5);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    request(1'b0, 16'hAA05);
    check("alias_hit", hit, 0);
    check("alias_wb", wb_pending, 0);

    // Reset mid-fill
    addr_offset_counter = 4'h5; #1;
    check("pre_rst_sdram", addr_sdram, 16'hAA05);
    rst = 1'b1; #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hit", hit, 0);
    check("mid_rst_sram", addr_sram, 0);
    check("mid_rst_sdram", addr_sdram, 0);
    check("mid_rst_wb", wb_pending, 0);
    step();
    rst = 1'b0;
    addr_offset_counter = 4'h0;
    step();
    request(1'b0, 16'h1230);
    check("post_rst_hit", hit, 0);
    check("post_rst_wb", wb_pending, 0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    request(1'b0, 16'hAAF5);
    check("post_rst_top_hit", hit, 0);
    check("post_rst_top_ldirty", line_dirty, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
